// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
//   arb_state_t : arbiter FSM states (idle, A owns channel, B owns channel)
//   last_t      : which requester most recently gave up the channel
//   SEL_A/SEL_B : mux select encodings (1 routes A, 0 routes B)
//   idle_pick   : tie-break helper used when the channel is free
package mux_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        LAST_B = 1'b0,
        LAST_A = 1'b1
    } last_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    // Picks the next owner of a free channel. On a tie the requester
    // that did not hold the channel most recently wins.
    function automatic arb_state_t idle_pick(input logic a_valid,
                                             input logic b_valid,
                                             input last_t last);
        arb_state_t pick;
        pick = IDLE;
        if (a_valid && b_valid) begin
            pick = (last == LAST_A) ? GNT_B : GNT_A;
        end else if (a_valid) begin
            pick = GNT_A;
        end else if (b_valid) begin
            pick = GNT_B;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_arbiter_parts.sv
// Building blocks used by mux_arbiter.
//
// burst_counter: counts accepted beats within one grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return count to zero (wins over inc)
//   inc        : add one accepted beat
//   count      : beats accepted so far in this grant
//   tc         : count has reached MAX_BURST-1 (next beat ends the burst)
//
// mux2: single-bit 2:1 mux, y = sel ? a : b.
module burst_counter #(
    parameter int MAX_BURST = 4,
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          tc
);

    // Beat counter; clear has priority so a burst-ending beat restarts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(MAX_BURST - 1));

endmodule

module mux2 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? a : b;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between two valid/ready
// requesters. The owner keeps the channel for up to MAX_BURST accepted
// beats, then the other requester gets it if it is waiting.
//   clk, rst_n          : clock, asynchronous active-low reset
//   a_data/a_valid/a_ready : requester A handshake
//   b_data/b_valid/b_ready : requester B handshake
//   out_data/out_valid/out_ready : downstream consumer handshake
//   sel                 : registered mux select (1 = A)
//   gnt_a, gnt_b        : A / B currently owns the channel
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel,
    output logic             gnt_a,
    output logic             gnt_b
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t    state;
    arb_state_t    state_next;
    last_t         last;
    last_t         last_next;
    logic          sel_next;
    logic          cnt_clear;
    logic          cnt_inc;
    logic          cnt_tc;
    logic [CW-1:0] count;

    logic          owner_valid;
    logic          other_valid;
    arb_state_t    other_state;
    logic          other_sel;
    last_t         owner_id;
    logic          beat;

    assign gnt_a = (state == GNT_A);
    assign gnt_b = (state == GNT_B);

    // Readies depend only on the registered grant and out_ready, never on valid.
    assign a_ready   = gnt_a & out_ready;
    assign b_ready   = gnt_b & out_ready;
    assign out_valid = (gnt_a & a_valid) | (gnt_b & b_valid);
    assign beat      = out_valid & out_ready;

    // Owner/other views of the requesters so both grant states share one rule set.
    always_comb begin
        owner_valid = 1'b0;
        other_valid = 1'b0;
        other_state = IDLE;
        other_sel   = SEL_B;
        owner_id    = LAST_B;
        if (state == GNT_A) begin
            owner_valid = a_valid;
            other_valid = b_valid;
            other_state = GNT_B;
            other_sel   = SEL_B;
            owner_id    = LAST_A;
        end else if (state == GNT_B) begin
            owner_valid = b_valid;
            other_valid = a_valid;
            other_state = GNT_A;
            other_sel   = SEL_A;
            owner_id    = LAST_B;
        end
    end

    // Arbitration state, last-releaser memory and mux select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= LAST_B;
            sel   <= SEL_B;
        end else begin
            state <= state_next;
            last  <= last_next;
            sel   <= sel_next;
        end
    end

    // Next-state rules: a dropped owner valid releases the channel, a
    // burst-ending beat hands over only if the other side is waiting,
    // and a stalled beat simply holds everything.
    always_comb begin
        state_next = state;
        last_next  = last;
        sel_next   = sel;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                state_next = idle_pick(a_valid, b_valid, last);
                if (state_next != IDLE) begin
                    cnt_clear = 1'b1;
                    sel_next  = (state_next == GNT_A) ? SEL_A : SEL_B;
                end
            end
            GNT_A, GNT_B: begin
                if (!owner_valid) begin
                    cnt_clear = 1'b1;
                    last_next = owner_id;
                    if (other_valid) begin
                        state_next = other_state;
                        sel_next   = other_sel;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (beat && cnt_tc) begin
                    cnt_clear = 1'b1;
                    if (other_valid) begin
                        state_next = other_state;
                        sel_next   = other_sel;
                        last_next  = owner_id;
                    end
                end else if (beat) begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    burst_counter #(
        .MAX_BURST (MAX_BURST),
        .CW        (CW)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (count),
        .tc    (cnt_tc)
    );

    // Datapath: one 2:1 mux per data bit, steered by the registered select.
    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux2 u_mux (
            .a   (a_data[i]),
            .b   (b_data[i]),
            .sel (sel),
            .y   (out_data[i])
        );
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter (WIDTH=8, MAX_BURST=4).
// Requester drivers replay per-side data queues with valid/ready; tests push
// the hand-ordered expected beats into a scoreboard that a negedge monitor
// pops whenever the DUT completes a downstream handshake.
module tb_mux_arbiter;
    import mux_arbiter_pkg::*;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic             src;
        logic [WIDTH-1:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             sel;
    logic             gnt_a;
    logic             gnt_b;

    int tests_run    = 0;
    int tests_failed = 0;

    beat_t            exp_q[$];
    logic [WIDTH-1:0] a_q[$];
    logic [WIDTH-1:0] b_q[$];
    logic             a_fire = 1'b0;
    logic             b_fire = 1'b0;
    int               beat_count = 0;
    int               a_beats = 0;
    int               b_beats = 0;
    int               cycle = 0;
    int               first_cyc = 0;
    int               last_cyc = 0;
    bit               gnt_b_seen = 1'b0;

    always #5 clk = ~clk;

    mux_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit to_a, input logic [WIDTH-1:0] d);
        if (to_a) a_q.push_back(d);
        else      b_q.push_back(d);
    endtask

    task automatic expectBeat(input bit src, input logic [WIDTH-1:0] d);
        beat_t e;
        e.src  = src;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Requester drivers: a beat that fired at the last edge is retired,
    // then valid/data present the head of each queue.
    always @(posedge clk) begin
        #1;
        if (a_fire && a_q.size() > 0) void'(a_q.pop_front());
        if (b_fire && b_q.size() > 0) void'(b_q.pop_front());
        a_valid = (a_q.size() > 0);
        a_data  = (a_q.size() > 0) ? a_q[0] : '0;
        b_valid = (b_q.size() > 0);
        b_data  = (b_q.size() > 0) ? b_q[0] : '0;
    end

    // Monitor: each downstream handshake is matched against the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        cycle++;
        a_fire = a_valid & a_ready;
        b_fire = b_valid & b_ready;
        if (gnt_b) gnt_b_seen = 1'b1;
        if (rst_n && out_valid && out_ready) begin
            beat_count++;
            if (a_fire) a_beats++;
            if (b_fire) b_beats++;
            if (beat_count == 1) first_cyc = cycle;
            last_cyc = cycle;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                checkOutput("beat_src", sel, e.src);
                checkOutput("beat_data", out_data, e.data);
                checkOutput("ready_route", {a_fire, b_fire}, e.src ? 2'b10 : 2'b01);
            end
        end
    end

    task automatic holdReset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        a_q.delete();
        b_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        beat_count = 0;
        a_beats    = 0;
        b_beats    = 0;
        gnt_b_seen = 1'b0;
    endtask

    task automatic doReset();
        holdReset();
        rst_n = 1'b1;
    endtask

    task automatic waitDrain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        checkOutput({name, "_drain"}, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic waitBeats(input string name, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (beat_count >= n) break;
            @(negedge clk);
            #1;
        end
        checkOutput({name, "_beats_reached"}, (beat_count >= n), 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        a_data    = '0;
        b_data    = '0;

        // Reset with both requesters valid: nothing granted or ready.
        holdReset();
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b0, 8'h22);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        checkOutput("reset_outputs", {gnt_a, gnt_b, sel, out_valid, a_ready, b_ready}, 6'b0);
        checkOutput("reset_count", dut.count, 0);
        out_ready = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_tie_grant", {gnt_a, gnt_b, sel}, 3'b101);

        // A alone for six beats: stays granted, burst wrap keeps the grant.
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(i));
            expectBeat(1'b1, 8'hA0 + 8'(i));
        end
        out_ready = 1'b1;
        waitDrain("a_only", 60);
        checkOutput("a_only_beats", a_beats, 6);
        checkOutput("a_only_back_to_back", last_cyc - first_cyc, 5);
        checkOutput("a_only_no_b_grant", gnt_b_seen, 0);

        // Both requesters busy: bursts of four alternate with no bubble.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'hC0 + 8'(i));
        for (int i = 0; i < 4; i++) expectBeat(1'b1, 8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) expectBeat(1'b0, 8'hC0 + 8'(i));
        for (int i = 4; i < 8; i++) expectBeat(1'b1, 8'h30 + 8'(i));
        out_ready = 1'b1;
        waitDrain("round_robin", 100);
        checkOutput("rr_no_idle", last_cyc - first_cyc, 11);
        checkOutput("rr_a_beats", a_beats, 8);
        checkOutput("rr_b_beats", b_beats, 4);

        // B stalls mid-burst: grant and count hold, no beat is lost.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h50 + 8'(i));
            expectBeat(1'b0, 8'h50 + 8'(i));
        end
        out_ready = 1'b1;
        waitBeats("stall", 2, 40);
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_hold", {gnt_b, b_ready, 1'b0, dut.count}, {1'b1, 1'b0, 1'b0, 3'd2});
        end
        out_ready = 1'b1;
        waitDrain("stall", 60);
        checkOutput("stall_b_beats", b_beats, 5);

        // A drops valid after two beats while B waits: immediate hand-over.
        doReset();
        applyStimulus(1'b1, 8'h61);
        applyStimulus(1'b1, 8'h62);
        applyStimulus(1'b0, 8'h71);
        applyStimulus(1'b0, 8'h72);
        expectBeat(1'b1, 8'h61);
        expectBeat(1'b1, 8'h62);
        expectBeat(1'b0, 8'h71);
        expectBeat(1'b0, 8'h72);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (gnt_b) break;
        end
        checkOutput("release_switch", {gnt_a, gnt_b, dut.count, logic'(dut.last)},
                    {1'b0, 1'b1, 3'd0, 1'b1});
        waitDrain("release", 40);
        checkOutput("release_b_beats", b_beats, 2);

        // Asynchronous reset in the middle of an A burst, then restart.
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h80 + 8'(i));
        expectBeat(1'b1, 8'h80);
        expectBeat(1'b1, 8'h81);
        out_ready = 1'b1;
        waitBeats("midreset", 2, 40);
        @(posedge clk);
        #2;
        checkOutput("midreset_count_before", dut.count, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_async_outputs", {gnt_a, gnt_b, out_valid, a_ready, b_ready, sel}, 6'b0);
        checkOutput("midreset_count_cleared", dut.count, 0);
        checkOutput("midreset_prior_beats", exp_q.size(), 0);
        holdReset();
        applyStimulus(1'b1, 8'h90);
        applyStimulus(1'b0, 8'hA9);
        expectBeat(1'b1, 8'h90);
        expectBeat(1'b0, 8'hA9);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        waitDrain("restart", 40);
        checkOutput("restart_beats", {a_beats[7:0], b_beats[7:0]}, {8'd1, 8'd1});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
